// File: rtl/injection_monitor_if.sv
// Bundle of the injection_monitor's observed channels, controls and results.
// The master side drives y1/y2/clear/arm; the slave side is the monitor itself.
interface injection_monitor_if #(
    parameter int unsigned CNT_W = 8,
    parameter int unsigned TS_W  = 16
);
    logic              y1;
    logic              y2;
    logic              clear;
    logic              arm;
    logic [CNT_W-1:0]  cnt1;
    logic [CNT_W-1:0]  cnt2;
    logic              stuck1;
    logic              stuck2;
    logic              busy;
    logic              done;
    logic              timeout;
    logic [1:0]        first_ch;
    logic [TS_W-1:0]   first_time;

    modport master (
        output y1, y2, clear, arm,
        input  cnt1, cnt2, stuck1, stuck2, busy, done, timeout, first_ch, first_time
    );

    modport slave (
        input  y1, y2, clear, arm,
        output cnt1, cnt2, stuck1, stuck2, busy, done, timeout, first_ch, first_time
    );
endinterface

// File: rtl/injection_monitor.sv
// Downstream monitor for the injection stage's y1/y2 outputs: per-channel
// saturating rising-edge counters, sticky stuck-high flags, and an armed
// first-edge capture with timer and timeout. All outputs come from flops.
module injection_monitor #(
    parameter int unsigned CNT_W       = 8,
    parameter int unsigned TS_W        = 16,
    parameter int unsigned STUCK_LIMIT = 32,
    parameter int unsigned TIMEOUT     = 1000
) (
    input logic                clk,
    input logic                rst,
    injection_monitor_if.slave bus
);

    localparam int unsigned     RunW      = 16;
    localparam logic [RunW-1:0] StuckLim  = RunW'(STUCK_LIMIT);
    localparam logic [RunW-1:0] StuckLast = RunW'(STUCK_LIMIT - 1);
    localparam logic [TS_W-1:0] TimerLast = TS_W'(TIMEOUT - 1);
    localparam logic [CNT_W-1:0] CntMax   = '1;

    typedef enum logic [1:0] {StIdle, StArmed, StDone} state_e;

    state_e           state_q, state_d;
    logic             y1_q, y2_q;
    logic [CNT_W-1:0] cnt1_q, cnt1_d, cnt2_q, cnt2_d;
    logic [RunW-1:0]  run1_q, run1_d, run2_q, run2_d;
    logic             stuck1_q, stuck1_d, stuck2_q, stuck2_d;
    logic [TS_W-1:0]  timer_q, timer_d;
    logic             timeout_q, timeout_d;
    logic [1:0]       first_ch_q, first_ch_d;
    logic [TS_W-1:0]  first_time_q, first_time_d;
    logic             e1, e2;

    // A channel already high when reset releases counts as an edge (y_q resets to 0).
    assign e1 = bus.y1 & ~y1_q;
    assign e2 = bus.y2 & ~y2_q;

    // Event counters, run-length counters and sticky stuck flags.
    always_comb begin
        cnt1_d   = cnt1_q;
        cnt2_d   = cnt2_q;
        run1_d   = run1_q;
        run2_d   = run2_q;
        stuck1_d = stuck1_q;
        stuck2_d = stuck2_q;
        if (bus.clear) begin
            cnt1_d   = '0;
            cnt2_d   = '0;
            run1_d   = '0;
            run2_d   = '0;
            stuck1_d = 1'b0;
            stuck2_d = 1'b0;
        end else begin
            if (e1 && cnt1_q != CntMax) cnt1_d = cnt1_q + 1'b1;
            if (e2 && cnt2_q != CntMax) cnt2_d = cnt2_q + 1'b1;

            if (!bus.y1)                run1_d = '0;
            else if (run1_q != StuckLim) run1_d = run1_q + 1'b1;
            if (!bus.y2)                run2_d = '0;
            else if (run2_q != StuckLim) run2_d = run2_q + 1'b1;

            // This sample is the STUCK_LIMIT-th consecutive high one.
            if (bus.y1 && run1_q >= StuckLast) stuck1_d = 1'b1;
            if (bus.y2 && run2_q >= StuckLast) stuck2_d = 1'b1;
        end
    end

    // First-edge capture FSM: next state, timer and result registers.
    always_comb begin
        state_d      = state_q;
        timer_d      = timer_q;
        timeout_d    = timeout_q;
        first_ch_d   = first_ch_q;
        first_time_d = first_time_q;
        if (bus.clear) begin
            state_d      = StIdle;
            timer_d      = '0;
            timeout_d    = 1'b0;
            first_ch_d   = 2'b00;
            first_time_d = '0;
        end else begin
            unique case (state_q)
                StIdle, StDone: begin
                    // Edges in the arm cycle itself are not captured.
                    if (bus.arm) begin
                        state_d      = StArmed;
                        timer_d      = '0;
                        timeout_d    = 1'b0;
                        first_ch_d   = 2'b00;
                        first_time_d = '0;
                    end
                end
                StArmed: begin
                    // An edge on the last timer cycle wins over the timeout.
                    if (e1 || e2) begin
                        state_d      = StDone;
                        first_ch_d   = {e2, e1};
                        first_time_d = timer_q;
                    end else if (timer_q == TimerLast) begin
                        state_d      = StDone;
                        timeout_d    = 1'b1;
                        first_ch_d   = 2'b00;
                        first_time_d = TimerLast;
                    end else begin
                        timer_d = timer_q + 1'b1;
                    end
                end
                default: state_d = StIdle;
            endcase
        end
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= StIdle;
            y1_q         <= 1'b0;
            y2_q         <= 1'b0;
            cnt1_q       <= '0;
            cnt2_q       <= '0;
            run1_q       <= '0;
            run2_q       <= '0;
            stuck1_q     <= 1'b0;
            stuck2_q     <= 1'b0;
            timer_q      <= '0;
            timeout_q    <= 1'b0;
            first_ch_q   <= 2'b00;
            first_time_q <= '0;
        end else begin
            state_q      <= state_d;
            y1_q         <= bus.y1;
            y2_q         <= bus.y2;
            cnt1_q       <= cnt1_d;
            cnt2_q       <= cnt2_d;
            run1_q       <= run1_d;
            run2_q       <= run2_d;
            stuck1_q     <= stuck1_d;
            stuck2_q     <= stuck2_d;
            timer_q      <= timer_d;
            timeout_q    <= timeout_d;
            first_ch_q   <= first_ch_d;
            first_time_q <= first_time_d;
        end
    end

    assign bus.cnt1       = cnt1_q;
    assign bus.cnt2       = cnt2_q;
    assign bus.stuck1     = stuck1_q;
    assign bus.stuck2     = stuck2_q;
    assign bus.busy       = (state_q == StArmed);
    assign bus.done       = (state_q == StDone);
    assign bus.timeout    = timeout_q;
    assign bus.first_ch   = first_ch_q;
    assign bus.first_time = first_time_q;

endmodule

// File: tb/tb_injection_monitor.sv
// Directed bench for injection_monitor with default parameters.
module tb_injection_monitor;

    localparam int unsigned CNT_W = 8;
    localparam int unsigned TS_W  = 16;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   tests = 0;
    int   fails = 0;

    injection_monitor_if #(.CNT_W(CNT_W), .TS_W(TS_W)) bus ();

    injection_monitor #(
        .CNT_W      (CNT_W),
        .TS_W       (TS_W),
        .STUCK_LIMIT(32),
        .TIMEOUT    (1000)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    // Advance past the next rising edge; inputs set before are sampled there.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        bus.y1 = 1'b1; bus.y2 = 1'b0; bus.clear = 1'b0; bus.arm = 1'b0;
        rst = 1'b1;
        tick(); tick();
        tests++;
        if ({bus.cnt1, bus.cnt2, bus.stuck1, bus.stuck2, bus.busy, bus.done, bus.timeout,
             bus.first_ch, bus.first_time} !== '0) begin
            fails++;
            $display("FAIL reset_state: cnt1=%0d cnt2=%0d busy=%b done=%b expected all zero",
                     bus.cnt1, bus.cnt2, bus.busy, bus.done);
        end
        rst = 1'b0;
        tick();
        tests++;
        if (bus.cnt1 !== 8'd1) begin
            fails++;
            $display("FAIL high_at_reset_edge: cnt1=%0d expected 1", bus.cnt1);
        end
        bus.y1 = 1'b0; bus.clear = 1'b1;
        tick();
        bus.clear = 1'b0;
    endtask

    task automatic test_pulses();
        for (int i = 0; i < 3; i++) begin
            bus.y1 = 1'b1; tick();
            if (i == 0) begin
                tests++;
                if (bus.cnt1 !== 8'd1) begin
                    fails++;
                    $display("FAIL pulse_first_edge: cnt1=%0d expected 1", bus.cnt1);
                end
            end
            bus.y1 = 1'b0; tick(); tick();
        end
        tests++;
        if ({bus.cnt1, bus.cnt2, bus.stuck1} !== {8'd3, 8'd0, 1'b0}) begin
            fails++;
            $display("FAIL pulse_counts: cnt1=%0d cnt2=%0d stuck1=%b expected 3 0 0",
                     bus.cnt1, bus.cnt2, bus.stuck1);
        end
    endtask

    task automatic test_stuck();
        bus.y2 = 1'b1;
        for (int i = 1; i <= 40; i++) begin
            tick();
            if (i == 31 || i == 32) begin
                tests++;
                if (bus.stuck2 !== (i == 32)) begin
                    fails++;
                    $display("FAIL stuck_after_%0d_samples: stuck2=%b expected %b",
                             i, bus.stuck2, (i == 32));
                end
            end
        end
        bus.y2 = 1'b0;
        tick();
        tests++;
        if ({bus.stuck2, bus.cnt2, bus.stuck1} !== {1'b1, 8'd1, 1'b0}) begin
            fails++;
            $display("FAIL stuck_sticky: stuck2=%b cnt2=%0d stuck1=%b expected 1 1 0",
                     bus.stuck2, bus.cnt2, bus.stuck1);
        end
        // Edge on y1 coincides with clear: clear wins.
        bus.clear = 1'b1; bus.y1 = 1'b1;
        tick();
        bus.clear = 1'b0; bus.y1 = 1'b0;
        tests++;
        if ({bus.stuck2, bus.cnt2, bus.cnt1} !== {1'b0, 8'd0, 8'd0}) begin
            fails++;
            $display("FAIL clear: stuck2=%b cnt2=%0d cnt1=%0d expected 0 0 0",
                     bus.stuck2, bus.cnt2, bus.cnt1);
        end
        tick();
    endtask

    task automatic test_capture();
        bus.arm = 1'b1; tick(); bus.arm = 1'b0;
        tests++;
        if ({bus.busy, bus.done} !== 2'b10) begin
            fails++;
            $display("FAIL arm_busy: busy=%b done=%b expected 1 0", bus.busy, bus.done);
        end
        repeat (5) tick();
        bus.y1 = 1'b1; tick(); bus.y1 = 1'b0;
        tests++;
        if ({bus.busy, bus.done, bus.timeout, bus.first_ch, bus.first_time} !==
            {1'b0, 1'b1, 1'b0, 2'b01, 16'd5}) begin
            fails++;
            $display("FAIL capture_y1: busy=%b done=%b to=%b ch=%b time=%0d expected 0 1 0 01 5",
                     bus.busy, bus.done, bus.timeout, bus.first_ch, bus.first_time);
        end
        tick();
        // Re-arm with a y2 edge in the arm cycle; that edge must be ignored.
        bus.arm = 1'b1; bus.y2 = 1'b1; tick(); bus.arm = 1'b0; bus.y2 = 1'b0;
        tick();
        tests++;
        if ({bus.busy, bus.done, bus.first_ch} !== {1'b1, 1'b0, 2'b00}) begin
            fails++;
            $display("FAIL rearm: busy=%b done=%b ch=%b expected 1 0 00",
                     bus.busy, bus.done, bus.first_ch);
        end
        // Now in timer=1; an arm at timer=3 is ignored.
        tick(); tick();
        bus.arm = 1'b1; tick(); bus.arm = 1'b0;
        repeat (8) tick();
        bus.y1 = 1'b1; bus.y2 = 1'b1; tick(); bus.y1 = 1'b0; bus.y2 = 1'b0;
        tests++;
        if ({bus.done, bus.timeout, bus.first_ch, bus.first_time} !==
            {1'b1, 1'b0, 2'b11, 16'd12}) begin
            fails++;
            $display("FAIL capture_both: done=%b to=%b ch=%b time=%0d expected 1 0 11 12",
                     bus.done, bus.timeout, bus.first_ch, bus.first_time);
        end
        tick();
    endtask

    task automatic test_timeout();
        bus.arm = 1'b1; tick(); bus.arm = 1'b0;
        repeat (999) tick();
        tests++;
        if ({bus.busy, bus.done} !== 2'b10) begin
            fails++;
            $display("FAIL timeout_last_busy: busy=%b done=%b expected 1 0", bus.busy, bus.done);
        end
        tick();
        tests++;
        if ({bus.busy, bus.done, bus.timeout, bus.first_ch, bus.first_time} !==
            {1'b0, 1'b1, 1'b1, 2'b00, 16'd999}) begin
            fails++;
            $display("FAIL timeout: busy=%b done=%b to=%b ch=%b time=%0d expected 0 1 1 00 999",
                     bus.busy, bus.done, bus.timeout, bus.first_ch, bus.first_time);
        end
        bus.arm = 1'b1; tick(); bus.arm = 1'b0;
        tests++;
        if ({bus.busy, bus.timeout} !== 2'b10) begin
            fails++;
            $display("FAIL rearm_clears_timeout: busy=%b to=%b expected 1 0",
                     bus.busy, bus.timeout);
        end
        repeat (999) tick();
        bus.y1 = 1'b1; tick(); bus.y1 = 1'b0;
        tests++;
        if ({bus.done, bus.timeout, bus.first_ch, bus.first_time} !==
            {1'b1, 1'b0, 2'b01, 16'd999}) begin
            fails++;
            $display("FAIL edge_on_last_cycle: done=%b to=%b ch=%b time=%0d expected 1 0 01 999",
                     bus.done, bus.timeout, bus.first_ch, bus.first_time);
        end
        tick();
    endtask

    task automatic test_saturate_and_reset();
        bus.clear = 1'b1; tick(); bus.clear = 1'b0;
        for (int i = 0; i < 300; i++) begin
            bus.y1 = 1'b1; tick();
            bus.y1 = 1'b0; tick();
            if (i == 254) begin
                tests++;
                if (bus.cnt1 !== 8'd255) begin
                    fails++;
                    $display("FAIL cnt_reach_max: cnt1=%0d expected 255", bus.cnt1);
                end
            end
        end
        tests++;
        if ({bus.cnt1, bus.cnt2} !== {8'd255, 8'd0}) begin
            fails++;
            $display("FAIL cnt_saturate: cnt1=%0d cnt2=%0d expected 255 0", bus.cnt1, bus.cnt2);
        end
        bus.arm = 1'b1; tick(); bus.arm = 1'b0;
        repeat (3) tick();
        tests++;
        if (bus.busy !== 1'b1) begin
            fails++;
            $display("FAIL armed_before_reset: busy=%b expected 1", bus.busy);
        end
        rst = 1'b1; tick(); rst = 1'b0;
        tests++;
        if ({bus.cnt1, bus.cnt2, bus.stuck1, bus.stuck2, bus.busy, bus.done, bus.timeout,
             bus.first_ch, bus.first_time} !== '0) begin
            fails++;
            $display("FAIL reset_mid_armed: cnt1=%0d busy=%b done=%b expected all zero",
                     bus.cnt1, bus.busy, bus.done);
        end
    endtask

    initial begin
        test_reset();
        test_pulses();
        test_stuck();
        test_capture();
        test_timeout();
        test_saturate_and_reset();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/injection_monitor.md
Name: injection_monitor

Overview:
- Downstream consumer of the injection stage's y1/y2 outputs.
- Counts assertion events per channel and flags channels stuck high.
- On request, captures which channel asserts first after arming, and how many cycles after arming it does so, with a timeout.
- Results feed the validation status path that checks whether an injected condition propagated.

Parameters:
- CNT_W, 8: width of each per-channel rising-edge event counter.
- TS_W, 16: width of the arm-to-first-edge timer and first_time output.
- STUCK_LIMIT, 32: consecutive high cycles on a channel that declare it stuck; range 1..2^16-1.
- TIMEOUT, 1000: cycles in ARMED before giving up; range 1..2^TS_W.

Ports:
- clk  input  1  system clock; all logic on rising edge.
- rst  input  1  synchronous, active-high reset.
- y1  input  1  channel 1 from the injection stage; already synchronous to clk.
- y2  input  1  channel 2 from the injection stage; already synchronous to clk.
- clear  input  1  synchronous clear of counters, stuck flags and capture results; FSM to IDLE.
- arm  input  1  one-cycle request to start a first-edge capture.
- cnt1  output  CNT_W  rising edges seen on y1; saturating.
- cnt2  output  CNT_W  rising edges seen on y2; saturating.
- stuck1  output  1  sticky: y1 was high for STUCK_LIMIT consecutive cycles.
- stuck2  output  1  sticky: y2 was high for STUCK_LIMIT consecutive cycles.
- busy  output  1  FSM in ARMED.
- done  output  1  FSM in DONE; results valid.
- timeout  output  1  capture ended with no edge; valid while done=1.
- first_ch  output  2  bit0 = y1 edge, bit1 = y2 edge in the capture cycle; 2'b11 means simultaneous.
- first_time  output  TS_W  timer value in the capture cycle.

Behaviour:
- All outputs are registered; there is no combinational path from input to output.
- Reset (rst=1 at a clk edge): all outputs 0, y1_q/y2_q=0, run counters=0, timer=0, FSM=IDLE. Reset overrides every other input, including mid-capture.
- Edge detect: e1 = y1 & ~y1_q, e2 = y2 & ~y2_q. y1_q/y2_q update every non-reset cycle, including clear cycles.
- A y input already high when leaving reset counts as an edge, because y_q resets to 0.
- Event counters: cntN increments on eN and saturates at 2^CNT_W-1 (no wrap). The updated value is visible in the cycle after the edge is sampled.
- Run counters: runN increments while yN=1 and saturates at STUCK_LIMIT; it goes to 0 when yN=0.
- Stuck flags: stuckN is set in the cycle after yN has been sampled high for STUCK_LIMIT consecutive cycles. It stays set until rst or clear, even if yN drops.
- clear=1: cnt, run, stuck, first_ch, first_time, done, timeout and timer go to 0, and the FSM goes to IDLE.
  - clear wins over a simultaneous edge, so that edge is not counted.
  - clear wins over a simultaneous arm.
- FSM states: IDLE, ARMED, DONE.
- IDLE:
  - busy=0, done=0.
  - arm=1 -> ARMED; timer=0; timeout=0; first_ch=0; first_time=0.
  - Edges occurring in the arm cycle are not captured.
- ARMED:
  - busy=1.
  - Edge case: if e1|e2 -> DONE; first_ch={e2,e1}; first_time=timer.
  - Timeout case: else if timer==TIMEOUT-1 -> DONE; timeout=1; first_ch=0; first_time=TIMEOUT-1.
  - Otherwise timer+1.
  - An edge on the final timer cycle counts as a capture, not a timeout.
  - arm while ARMED is ignored.
- DONE:
  - done=1; results held.
  - arm=1 -> ARMED with the same initialisation as from IDLE; done drops the next cycle.
- Counting and stuck detection run in every FSM state; they are independent of arm.
- The timer never wraps, because TIMEOUT <= 2^TS_W.

Test Plan:
- Reset with y1=y2=0, then 3 pulses on y1, each 1 cycle high / 2 low -> cnt1=3, cnt2=0, stuck1=0.
- y2 held high for 40 cycles with STUCK_LIMIT=32 -> stuck2=1 from the cycle after the 32nd high sample; cnt2=1; stuck2 stays 1 after y2 drops; clear -> stuck2=0, cnt2=0.
- arm, then y1 rises on the 6th cycle after arm (timer=5) -> done=1, first_ch=01, first_time=5, timeout=0; re-arm -> done=0, busy=1.
- arm, then y1 and y2 rise in the same cycle at timer=12 -> first_ch=11, first_time=12.
- arm with TIMEOUT=1000 and no edges -> busy for 1000 cycles, then done=1, timeout=1, first_ch=00, first_time=999; repeat with an edge exactly at timer=999 -> timeout=0, first_time=999.
- 300 y1 pulses with CNT_W=8 -> cnt1=255 (saturated); rst asserted mid-ARMED -> all outputs 0 the next cycle.
